regfile_sb: RTL and testbench

//   General-purpose register file serving the decode stage's two read requests
//   (read enable + 5-bit address per port) and the writeback stage's single write.

---
 rtl/regfile_sb.sv | 105 ++++++++++
 tb/tb_regfile_sb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - two-read/one-write register file with write bypass and hardwired $0
// Define REGFILE_SCOREBOARD_EN to build the pending-write scoreboard, busy flags and stallreq.
module regfile_sb #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_waddr,
  input  logic              flush,
  output logic              busy1,
  output logic              busy2,
  output logic              stallreq,
  output logic              sb_ovf
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              en,
    input logic [ADDR_W-1:0] a,
    input logic              wen,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    if (!en || a == '0) return '0;
    if (wen && wa == a) return wd;
    return stored;
  endfunction

  // Outputs are forced to zero during reset so an active bypass cannot leak through.
  assign rdata1 = rst ? '0 : read_port(re1, raddr1, we, waddr, wdata, regs[raddr1]);
  assign rdata2 = rst ? '0 : read_port(re2, raddr2, we, waddr, wdata, regs[raddr2]);

`ifdef REGFILE_SCOREBOARD_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0]   pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                hit1;
  logic                hit2;

  // Bit 0 is masked so $0 is never tracked; pend[0] therefore stays zero.
  assign inc_vec = ((issue_valid && issue_we) ? (NUM_REGS'(1) << issue_waddr) : '0) & ~NUM_REGS'(1);
  assign dec_vec = (we ? (NUM_REGS'(1) << waddr) : '0) & ~NUM_REGS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= '{default: '0};
      sb_ovf <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (flush) begin
          pend[r[ADDR_W-1:0]] <= '0;
        end else if (inc_vec[r[ADDR_W-1:0]] && !dec_vec[r[ADDR_W-1:0]]) begin
          if (pend[r[ADDR_W-1:0]] == PEND_MAX) sb_ovf <= 1'b1;
          else pend[r[ADDR_W-1:0]] <= pend[r[ADDR_W-1:0]] + 1'b1;
        end else if (dec_vec[r[ADDR_W-1:0]] && !inc_vec[r[ADDR_W-1:0]] &&
                     pend[r[ADDR_W-1:0]] != '0) begin
          pend[r[ADDR_W-1:0]] <= pend[r[ADDR_W-1:0]] - 1'b1;
        end
      end
    end
  end

  // A writeback retiring the last pending write this cycle resolves the hazard via bypass.
  assign hit1  = we && (waddr == raddr1);
  assign hit2  = we && (waddr == raddr2);
  assign busy1 = !rst && re1 && (raddr1 != '0) && (pend[raddr1] > PEND_W'(hit1));
  assign busy2 = !rst && re2 && (raddr2 != '0) && (pend[raddr2] > PEND_W'(hit2));
  assign stallreq = busy1 | busy2;
`else
  logic unused_sb;

  assign unused_sb = ^{issue_valid, issue_we, issue_waddr, flush};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
  assign stallreq  = 1'b0;
  assign sb_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb
// Scoreboard scenarios run when REGFILE_SCOREBOARD_EN is defined, the tied-off checks otherwise.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_waddr;
  logic        flush;
  logic        busy1;
  logic        busy2;
  logic        stallreq;
  logic        sb_ovf;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  exp_t exp_q [$];

  regfile_sb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_waddr(issue_waddr),
    .flush(flush), .busy1(busy1), .busy2(busy2), .stallreq(stallreq), .sb_ovf(sb_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    issue_valid = 1'b0; issue_we = 1'b0; issue_waddr = '0; flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] d);
    issue_valid = 1'b1; issue_we = 1'b1; issue_waddr = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd0,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd1,  32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd5,  1'b1, 5'd31, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 5'd5,  32'h12345678, 1'b1, 5'd5,  1'b1, 5'd31, 32'h12345678, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 5'd31, 32'h0,        1'b1, 5'd5,  1'b1, 5'd31, 32'h12345678, 32'hA5A5A5A5};
    vecs[7] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd1,  1'b1, 5'd2,  32'h00000001, 32'h0};

    idle();
    rst = 1'b1;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
    #12;
    chk("reset_rdata1", rdata1, 32'h0);
    chk("reset_rdata2", rdata2, 32'h0);
    chk("reset_busy1", busy1, 0);
    chk("reset_busy2", busy2, 0);
    chk("reset_stallreq", stallreq, 0);
    chk("reset_sb_ovf", sb_ovf, 0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      idle();
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re1 = vecs[i].re1; raddr1 = vecs[i].raddr1;
      re2 = vecs[i].re2; raddr2 = vecs[i].raddr2;
      exp_q.push_back('{vecs[i].exp1, vecs[i].exp2});
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_rdata1", i), rdata1, e.e1);
      chk($sformatf("vec%0d_rdata2", i), rdata2, e.e2);
      tick();
    end

`ifdef REGFILE_SCOREBOARD_EN
    // RAW hazard on $7 resolved by a same-cycle writeback
    idle(); issue(5'd7); re2 = 1'b1; raddr2 = 5'd7;
    @(negedge clk);
    chk("s3_busy2_issue_cycle", busy2, 0);
    tick();
    idle(); re2 = 1'b1; raddr2 = 5'd7;
    @(negedge clk);
    chk("s3_busy2_hazard", busy2, 1);
    chk("s3_stallreq_hazard", stallreq, 1);
    tick();
    idle(); re2 = 1'b1; raddr2 = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h00007777;
    @(negedge clk);
    chk("s3_busy2_wb", busy2, 0);
    chk("s3_stallreq_wb", stallreq, 0);
    chk("s3_rdata2_bypass", rdata2, 32'h00007777);
    tick();
    idle(); re2 = 1'b1; raddr2 = 5'd7;
    @(negedge clk);
    chk("s3_busy2_after", busy2, 0);
    chk("s3_rdata2_stored", rdata2, 32'h00007777);
    tick();

    // Saturating count on $9
    for (int k = 0; k < 3; k++) begin
      idle(); issue(5'd9);
      tick();
    end
    idle(); issue(5'd9); re1 = 1'b1; raddr1 = 5'd9;
    @(negedge clk);
    chk("s4_busy1_pend3", busy1, 1);
    chk("s4_sb_ovf_before", sb_ovf, 0);
    tick();
    for (int j = 0; j < 3; j++) begin
      idle(); re1 = 1'b1; raddr1 = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'(j + 1);
      @(negedge clk);
      chk($sformatf("s4_busy1_wb%0d", j), busy1, (j < 2) ? 1 : 0);
      chk($sformatf("s4_sb_ovf_wb%0d", j), sb_ovf, 1);
      tick();
    end
    idle(); re1 = 1'b1; raddr1 = 5'd9;
    @(negedge clk);
    chk("s4_busy1_drained", busy1, 0);
    chk("s4_rdata1", rdata1, 32'h3);
    tick();

    // Simultaneous issue/writeback, then flush
    idle(); issue(5'd4);
    tick();
    idle(); issue(5'd4); we = 1'b1; waddr = 5'd4; wdata = 32'h44; re1 = 1'b1; raddr1 = 5'd4;
    @(negedge clk);
    chk("s5_busy1_simul", busy1, 0);
    chk("s5_rdata1_simul", rdata1, 32'h44);
    tick();
    idle(); re1 = 1'b1; raddr1 = 5'd4;
    @(negedge clk);
    chk("s5_busy1_unchanged", busy1, 1);
    tick();
    idle(); issue(5'd6); flush = 1'b1;
    tick();
    idle(); re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd6;
    @(negedge clk);
    chk("s5_busy1_flushed", busy1, 0);
    chk("s5_busy2_flushed", busy2, 0);
    chk("s5_stallreq_flushed", stallreq, 0);
    chk("s5_sb_ovf_sticky", sb_ovf, 1);
    tick();
    idle(); we = 1'b1; waddr = 5'd6; wdata = 32'h66;
    tick();
    idle(); re2 = 1'b1; raddr2 = 5'd6;
    @(negedge clk);
    chk("s5_busy2_untracked_wb", busy2, 0);
    chk("s5_rdata2_untracked_wb", rdata2, 32'h66);
    tick();
`else
    // Scoreboard absent: hazard sequence never stalls
    idle(); issue(5'd7);
    tick();
    idle(); re2 = 1'b1; raddr2 = 5'd7;
    @(negedge clk);
    chk("s6_busy2", busy2, 0);
    chk("s6_stallreq", stallreq, 0);
    tick();
    idle(); re2 = 1'b1; raddr2 = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h00007777;
    @(negedge clk);
    chk("s6_busy2_wb", busy2, 0);
    chk("s6_rdata2_bypass", rdata2, 32'h00007777);
    chk("s6_sb_ovf", sb_ovf, 0);
    tick();
`endif

    // Asynchronous reset in the middle of operation
    idle(); we = 1'b1; waddr = 5'd3; wdata = 32'h1234;
    tick();
    idle(); re1 = 1'b1; raddr1 = 5'd3;
    @(negedge clk);
    chk("s1_rdata1_before", rdata1, 32'h1234);
    @(posedge clk);
    #2;
    rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h5555;
    #1;
    chk("s1_rdata1_in_rst", rdata1, 32'h0);
    chk("s1_sb_ovf_in_rst", sb_ovf, 0);
    chk("s1_stallreq_in_rst", stallreq, 0);
    tick();
    rst = 1'b0;
    idle(); re1 = 1'b1; raddr1 = 5'd3;
    @(negedge clk);
    chk("s1_rdata1_after", rdata1, 32'h0);
    chk("s1_sb_ovf_after", sb_ovf, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
